// File: rtl/axi4f_burst_ctrl_pkg.sv
// Shared types and constants for the AXI4-full burst controller.
package axi4f_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StFin
  } state_t;

  localparam logic [2:0] SIZE_4BYTE  = 3'b010;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True when a burst of len+1 4-byte beats starting at addr runs past a 4 KB page.
  function automatic logic crosses_4k(logic [11:0] addr, logic [7:0] len);
    logic [13:0] end_byte;
    end_byte = {2'b00, addr} + (({6'b000000, len} + 14'd1) << 2);
    return end_byte > 14'd4096;
  endfunction

endpackage

// File: rtl/axi4f_burst_ctrl_if.sv
// Bundle of the local command/data streams and the AXI4 master bus.
interface axi4f_burst_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;

  logic              wd_valid;
  logic              wd_ready;
  logic [31:0]       wd_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_data;
  logic              rd_last;

  logic              done;
  logic [1:0]        resp;

  logic [3:0]        m_axi_awid;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready;

  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;

  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  logic [3:0]        m_axi_arid;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;

  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  // Controller side.
  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output cmd_ready,
    input  wd_valid, wd_data,
    output wd_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output done, resp,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  // Requester plus AXI slave side.
  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  cmd_ready,
    output wd_valid, wd_data,
    input  wd_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  done, resp,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi4f_burst_ctrl_beat_ctr.sv
// Beat counter shared by the W and R phases; flags the beat whose index equals len.
module axi4f_beat_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       is_last
);
  logic [7:0] cnt;

  // Restart at each address handshake, advance on each data beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign is_last = (cnt == len);
endmodule

// File: rtl/axi4f_burst_ctrl.sv
// Command-driven AXI4-full INCR burst master, one command in flight.
// Optional build macro AXI4F_4K_CHECK_EN rejects bursts that cross a 4 KB page.
module axi4f_burst_ctrl
  import axi4f_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_LEN = 16,
  parameter logic [3:0]  AXI_ID  = 4'd0
) (
  input logic                clk,
  input logic                rst,
  axi4f_burst_ctrl_if.master bus
);
  localparam logic [8:0] LenMax = 9'(MAX_LEN - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic              cmd_ready_q;
  logic              awvalid_q;
  logic              arvalid_q;
  logic              bready_q;
  logic              done_q;
  logic [1:0]        resp_q;

  logic              is_last;
  logic              w_beat;
  logic              r_beat;
  logic              beat_clr;
  logic              reject;
  logic [1:0]        rresp_max;
  logic [1:0]        rresp_next;

  assign w_beat   = (state == StW) && bus.wd_valid && bus.m_axi_wready;
  assign r_beat   = (state == StR) && bus.m_axi_rvalid && bus.rd_ready;
  assign beat_clr = ((state == StAw) && awvalid_q && bus.m_axi_awready) ||
                    ((state == StAr) && arvalid_q && bus.m_axi_arready);

  axi4f_beat_ctr u_beat_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (beat_clr),
    .inc     (w_beat || r_beat),
    .len     (len_q),
    .is_last (is_last)
  );

  // Commands the controller refuses to put on the bus.
  always_comb begin
    reject = ({1'b0, bus.cmd_len} > LenMax);
`ifdef AXI4F_4K_CHECK_EN
    if (crosses_4k({bus.cmd_addr[11:2], 2'b00}, bus.cmd_len)) reject = 1'b1;
`endif
  end

  // Read response: worst rresp so far; a premature rlast degrades OKAY to SLVERR.
  always_comb begin
    rresp_max  = (bus.m_axi_rresp > resp_q) ? bus.m_axi_rresp : resp_q;
    rresp_next = rresp_max;
    if (bus.m_axi_rlast && !is_last && (rresp_max == RESP_OKAY)) rresp_next = RESP_SLVERR;
  end

  // Burst sequencing FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= StIdle;
      addr_q      <= '0;
      len_q       <= 8'd0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= RESP_OKAY;
    end else begin
      unique case (state)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= {bus.cmd_addr[ADDR_W-1:2], 2'b00};
            len_q       <= bus.cmd_len;
            resp_q      <= RESP_OKAY;
            if (reject) begin
              resp_q <= RESP_SLVERR;
              done_q <= 1'b1;
              state  <= StFin;
            end else if (bus.cmd_wr) begin
              awvalid_q <= 1'b1;
              state     <= StAw;
            end else begin
              arvalid_q <= 1'b1;
              state     <= StAr;
            end
          end
        end
        StAw: begin
          if (bus.m_axi_awready) begin
            awvalid_q <= 1'b0;
            state     <= StW;
          end
        end
        StW: begin
          if (w_beat && is_last) begin
            bready_q <= 1'b1;
            state    <= StB;
          end
        end
        StB: begin
          if (bus.m_axi_bvalid) begin
            bready_q <= 1'b0;
            resp_q   <= bus.m_axi_bresp;
            done_q   <= 1'b1;
            state    <= StFin;
          end
        end
        StAr: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= StR;
          end
        end
        StR: begin
          if (r_beat) begin
            resp_q <= rresp_next;
            if (bus.m_axi_rlast) begin
              done_q <= 1'b1;
              state  <= StFin;
            end
          end
        end
        StFin: begin
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.done          = done_q;
  assign bus.resp          = resp_q;

  assign bus.m_axi_awid    = AXI_ID;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = len_q;
  assign bus.m_axi_awsize  = SIZE_4BYTE;
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awvalid = awvalid_q;

  // Write data streams straight through while in the W phase.
  assign bus.m_axi_wdata   = bus.wd_data;
  assign bus.m_axi_wstrb   = 4'hF;
  assign bus.m_axi_wvalid  = (state == StW) && bus.wd_valid;
  assign bus.m_axi_wlast   = (state == StW) && is_last;
  assign bus.wd_ready      = (state == StW) && bus.m_axi_wready;

  assign bus.m_axi_bready  = bready_q;

  assign bus.m_axi_arid    = AXI_ID;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = len_q;
  assign bus.m_axi_arsize  = SIZE_4BYTE;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arvalid = arvalid_q;

  // Read data streams straight through while in the R phase.
  assign bus.rd_valid      = (state == StR) && bus.m_axi_rvalid;
  assign bus.rd_data       = bus.m_axi_rdata;
  assign bus.rd_last       = (state == StR) && bus.m_axi_rlast;
  assign bus.m_axi_rready  = (state == StR) && bus.rd_ready;
endmodule

// File: tb/tb_axi4f_burst_ctrl.sv
// Bench for axi4f_burst_ctrl: requester + AXI slave memory model around the DUT.
module tb_axi4f_burst_ctrl;
  import axi4f_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi4f_burst_ctrl_if #(.ADDR_W(32)) bus ();

  axi4f_burst_ctrl #(
    .ADDR_W  (32),
    .MAX_LEN (16),
    .AXI_ID  (4'h5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Slave memory, word indexed; unwritten words read back as a hash of the index.
  logic [31:0] mem [int unsigned];
  function automatic logic [31:0] mem_rd(input int unsigned widx);
    if (mem.exists(widx)) return mem[widx];
    return widx * 32'h9E37_79B1;
  endfunction

  // Current command as the model sees it.
  bit          c_wr, c_rej;
  logic [31:0] c_addr;
  int          c_len, c_mode, rlast_at, stall_cnt;
  logic [1:0]  c_bresp;
  logic [31:0] wdata_q [$];
  logic [1:0]  rresp_v [256];

  // Progress of the current command.
  bit   cmd_on, accepted, aw_seen, ar_seen, b_pend;
  int   cyc, acc_cyc, first_addr_cyc, done_cyc, done_cnt;
  int   aw_cnt, ar_cnt, wbeat, rbeat;
  logic [1:0] done_resp;

  function automatic bit rnd(input int mode);
    return (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endfunction

  // One clock: drive inputs at the falling edge, then record the handshakes due next rise.
  task automatic step();
    bit go;
    @(negedge clk);
    cyc++;
    bus.cmd_valid = cmd_on;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = 32'h0;
    if (c_wr && !c_rej && wbeat <= c_len) begin
      go = rnd(c_mode);
      if (c_mode == 2) begin
        go = 1'b1;
        if (wbeat == 1 && stall_cnt < 2) begin
          go = 1'b0;
          stall_cnt++;
        end
      end
      bus.wd_valid = go;
      bus.wd_data  = wdata_q[wbeat];
    end
    bus.rd_ready      = rnd(c_mode);
    bus.m_axi_awready = rnd(c_mode);
    bus.m_axi_wready  = (c_mode == 2) ? 1'(cyc & 1) : rnd(c_mode);
    bus.m_axi_bvalid  = b_pend && rnd(c_mode);
    bus.m_axi_bresp   = c_bresp;
    bus.m_axi_arready = rnd(c_mode);
    bus.m_axi_rvalid  = ar_seen && (rbeat <= rlast_at) && rnd(c_mode);
    bus.m_axi_rdata   = mem_rd((c_addr >> 2) + rbeat);
    bus.m_axi_rresp   = (rbeat < 256) ? rresp_v[rbeat] : 2'b00;
    bus.m_axi_rlast   = (rbeat == rlast_at);
    #1;
    if (bus.cmd_valid && bus.cmd_ready) begin
      accepted = 1'b1;
      cmd_on   = 1'b0;
      acc_cyc  = cyc;
    end
    if ((bus.m_axi_awvalid || bus.m_axi_arvalid) && first_addr_cyc < 0) first_addr_cyc = cyc;
    if (bus.m_axi_awvalid && bus.m_axi_awready) begin
      aw_cnt++;
      aw_seen = 1'b1;
      check_eq("awaddr", bus.m_axi_awaddr, c_addr);
      check_eq("awlen", bus.m_axi_awlen, c_len);
      check_eq("aw_id_size_burst", {bus.m_axi_awid, bus.m_axi_awsize, bus.m_axi_awburst},
               {4'h5, 3'b010, 2'b01});
    end
    if (bus.m_axi_wvalid && bus.m_axi_wready) begin
      check_eq("w_after_aw", aw_seen, 1);
      check_eq("wd_ready", bus.wd_ready, 1);
      check_eq("wstrb", bus.m_axi_wstrb, 4'hF);
      if (wbeat <= c_len) begin
        check_eq("wdata", bus.m_axi_wdata, wdata_q[wbeat]);
        check_eq("wlast", bus.m_axi_wlast, (wbeat == c_len));
        mem[(c_addr >> 2) + wbeat] = bus.m_axi_wdata;
      end else begin
        check_eq("w_extra_beat", wbeat, c_len);
      end
      wbeat++;
      if (wbeat == c_len + 1) b_pend = 1'b1;
    end
    if (bus.m_axi_bvalid && bus.m_axi_bready) b_pend = 1'b0;
    if (bus.m_axi_arvalid && bus.m_axi_arready) begin
      ar_cnt++;
      ar_seen = 1'b1;
      check_eq("araddr", bus.m_axi_araddr, c_addr);
      check_eq("arlen", bus.m_axi_arlen, c_len);
      check_eq("ar_id_size_burst", {bus.m_axi_arid, bus.m_axi_arsize, bus.m_axi_arburst},
               {4'h5, 3'b010, 2'b01});
    end
    if (bus.m_axi_rvalid && bus.m_axi_rready) begin
      check_eq("rd_valid", bus.rd_valid, 1);
      check_eq("rd_data", bus.rd_data, mem_rd((c_addr >> 2) + rbeat));
      check_eq("rd_last", bus.rd_last, (rbeat == rlast_at));
      rbeat++;
    end
    if (bus.done) begin
      done_cnt++;
      done_resp = bus.resp;
      done_cyc  = cyc;
    end
  endtask

  // Load the model with a command and present it to the DUT.
  task automatic start_cmd(input bit wr, input logic [31:0] addr, input int len,
                           input int mode, input int early, input bit rnd_resp);
    c_wr   = wr;
    c_addr = addr & 32'hFFFF_FFFC;
    c_len  = len;
    c_mode = mode;
    c_rej  = (len > 15);
`ifdef AXI4F_4K_CHECK_EN
    if ((c_addr & 32'hFFF) + (len + 1) * 4 > 4096) c_rej = 1'b1;
`endif
    wdata_q.delete();
    for (int i = 0; i <= len; i++) begin
      wdata_q.push_back(rnd_resp ? $urandom : 32'hA1 + i);
      rresp_v[i] = (rnd_resp && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    c_bresp  = (rnd_resp && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    rlast_at = (early >= 0) ? early : len;
    stall_cnt = 0;
    accepted = 0; aw_seen = 0; ar_seen = 0; b_pend = 0;
    first_addr_cyc = -1; acc_cyc = 0; done_cyc = 0; done_cnt = 0;
    aw_cnt = 0; ar_cnt = 0; wbeat = 0; rbeat = 0; done_resp = 2'b00;
    bus.cmd_wr   = wr;
    bus.cmd_addr = addr;
    bus.cmd_len  = 8'(len);
    cmd_on       = 1'b1;
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len,
                         input int mode, input int early, input bit rnd_resp);
    int n;
    logic [1:0] exp_resp;
    start_cmd(wr, addr, len, mode, early, rnd_resp);
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      step();
      n++;
    end
    check_eq("done_seen", done_cnt, 1);
    step();
    check_eq("done_one_cycle", done_cnt, 1);
    if (c_rej) begin
      exp_resp = 2'b10;
      check_eq("rej_no_traffic", aw_cnt + ar_cnt, 0);
      check_eq("rej_done_latency", done_cyc - acc_cyc, 1);
    end else if (wr) begin
      exp_resp = c_bresp;
      check_eq("aw_once", {aw_cnt, ar_cnt}, {32'd1, 32'd0});
      check_eq("aw_latency", first_addr_cyc - acc_cyc, 1);
      check_eq("w_beats", wbeat, len + 1);
      for (int i = 0; i <= len; i++)
        check_eq("mem_backdoor", mem_rd((c_addr >> 2) + i), wdata_q[i]);
    end else begin
      exp_resp = 2'b00;
      for (int i = 0; i <= rlast_at; i++)
        if (rresp_v[i] > exp_resp) exp_resp = rresp_v[i];
      if (rlast_at < len && exp_resp == 2'b00) exp_resp = 2'b10;
      check_eq("ar_once", {ar_cnt, aw_cnt}, {32'd1, 32'd0});
      check_eq("ar_latency", first_addr_cyc - acc_cyc, 1);
      check_eq("r_beats", rbeat, rlast_at + 1);
    end
    check_eq("resp", done_resp, exp_resp);
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid,
                   bus.m_axi_rready, bus.rd_valid, bus.wd_ready, bus.cmd_ready, bus.done,
                   bus.resp, bus.m_axi_awaddr, bus.m_axi_awlen}, 51'd0);
  endtask

  task automatic idle_inputs();
    cmd_on = 0; c_wr = 0; c_rej = 0; c_len = 0; c_mode = 0; rlast_at = -1;
    ar_seen = 0; b_pend = 0; wbeat = 0; rbeat = 0; c_addr = 0; c_bresp = 0;
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
    bus.wd_valid = 0; bus.wd_data = 0; bus.rd_ready = 0;
    bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
    bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
    bus.m_axi_rlast = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    @(negedge clk);
    rst = 1'b1;

    run_cmd(1'b1, 32'h44A0_0000, 3, 1, -1, 1'b0);   // write, slave always ready
    run_cmd(1'b0, 32'h44A0_0000, 3, 1, -1, 1'b0);   // read back the same words
    run_cmd(1'b1, 32'h44A0_0101, 3, 2, -1, 1'b0);   // stalled wd_valid, toggling wready
    run_cmd(1'b1, 32'h44A0_0200, 16, 1, -1, 1'b0);  // over-length command
    run_cmd(1'b1, 32'h44A0_0FF8, 3, 1, -1, 1'b0);   // 4 KB boundary crossing
    run_cmd(1'b0, 32'h44A0_0000, 3, 0, 1, 1'b0);    // early rlast

    // Reset in the middle of a len=7 write.
    start_cmd(1'b1, 32'h44A0_0300, 7, 1, -1, 1'b0);
    n = 0;
    while (wbeat < 2 && n < 100) begin
      step();
      n++;
    end
    check_eq("pre_reset_beats", wbeat, 2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_quiet("mid_burst_reset");
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    run_cmd(1'b0, 32'h44A0_0300, 1, 1, -1, 1'b0);   // accepted after reset release

    for (int k = 0; k < 24; k++)
      run_cmd(1'($urandom_range(0, 1)), 32'h44A0_0000 + $urandom_range(0, 4095),
              $urandom_range(0, 17), 0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
